// File: rtl/int_ack_ctrl.sv
// Interrupt acknowledge controller: fixed-priority request/ack/eret handshake towards the CPU.
// Optional ack-wait timeout enabled by defining INT_ACK_TIMEOUT_EN.
module int_ack_ctrl #(
    parameter int          N_SRC      = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter int          VEC_STRIDE = 8,
    parameter int          TIMEOUT    = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_SRC-1:0]         int_pend,
    input  logic [N_SRC-1:0]         int_mask,
    input  logic                     cpu_int_ack,
    input  logic                     cpu_eret,
    output logic                     cpu_int_req,
    output logic [$clog2(N_SRC)-1:0] int_id,
    output logic [31:0]              int_vec,
    output logic [N_SRC-1:0]         int_clr,
    output logic                     int_busy,
    output logic                     int_err
);

    localparam int ID_W = $clog2(N_SRC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

    state_t            state_reg;
    logic [N_SRC-1:0]  elig;
    logic [ID_W-1:0]   win_id;
    logic [31:0]       vec_tab [N_SRC];

    generate
        if (N_SRC < 2 || N_SRC > 16 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
            $error("int_ack_ctrl: parameter out of range");
        end
    endgenerate

    // Vector table is constant; the 32-bit sum wraps naturally.
    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_vec
            assign vec_tab[gi] = VEC_BASE + 32'(gi * VEC_STRIDE);
        end
    endgenerate

    assign elig = int_pend & int_mask;

    always_comb begin
        win_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

`ifdef INT_ACK_TIMEOUT_EN
    logic [15:0] tmo_cnt_reg;
    logic        err_reg;
    assign int_err = err_reg;
`else
    assign int_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cpu_int_req <= 1'b0;
            int_id      <= '0;
            int_vec     <= '0;
            int_clr     <= '0;
            int_busy    <= 1'b0;
`ifdef INT_ACK_TIMEOUT_EN
            tmo_cnt_reg <= '0;
            err_reg     <= 1'b0;
`endif
        end else begin
            int_clr <= '0;
            case (state_reg)
                IDLE: begin
                    if (|elig) begin
                        state_reg   <= REQ;
                        int_id      <= win_id;
                        int_vec     <= vec_tab[win_id];
                        cpu_int_req <= 1'b1;
                        int_busy    <= 1'b1;
`ifdef INT_ACK_TIMEOUT_EN
                        tmo_cnt_reg <= '0;
`endif
                    end
                end
                REQ: begin
                    // Ack has priority over both eret and timeout expiry.
                    if (cpu_int_ack) begin
                        state_reg   <= SERV;
                        cpu_int_req <= 1'b0;
                        int_clr     <= N_SRC'(1) << int_id;
                    end
`ifdef INT_ACK_TIMEOUT_EN
                    else if (tmo_cnt_reg == 16'(TIMEOUT - 1)) begin
                        state_reg   <= IDLE;
                        cpu_int_req <= 1'b0;
                        int_busy    <= 1'b0;
                        err_reg     <= 1'b1;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
                    end
`endif
                end
                SERV: begin
                    if (cpu_eret) begin
                        state_reg <= IDLE;
                        int_busy  <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    cpu_int_req <= 1'b0;
                    int_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_ack_ctrl.sv
// Directed bench for int_ack_ctrl (N_SRC=4, TIMEOUT=4); expected values computed by hand.
module tb_int_ack_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  int_pend;
    logic [3:0]  int_mask;
    logic        cpu_int_ack;
    logic        cpu_eret;
    logic        cpu_int_req;
    logic [1:0]  int_id;
    logic [31:0] int_vec;
    logic [3:0]  int_clr;
    logic        int_busy;
    logic        int_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    int_ack_ctrl #(
        .N_SRC      (4),
        .VEC_BASE   (32'h0000_0100),
        .VEC_STRIDE (8),
        .TIMEOUT    (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .int_pend    (int_pend),
        .int_mask    (int_mask),
        .cpu_int_ack (cpu_int_ack),
        .cpu_eret    (cpu_eret),
        .cpu_int_req (cpu_int_req),
        .int_id      (int_id),
        .int_vec     (int_vec),
        .int_clr     (int_clr),
        .int_busy    (int_busy),
        .int_err     (int_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        int_pend    = 4'b1111;
        int_mask    = 4'b1111;
        cpu_int_ack = 1'b0;
        cpu_eret    = 1'b0;
        tick(); tick(); tick();
        chk("rst_req",  32'(cpu_int_req), 32'd0);
        chk("rst_clr",  32'(int_clr),     32'd0);
        chk("rst_id",   32'(int_id),      32'd0);
        chk("rst_vec",  int_vec,          32'd0);
        chk("rst_busy", 32'(int_busy),    32'd0);
        chk("rst_err",  32'(int_err),     32'd0);

        // single source 2
        rst_n = 1'b1; int_pend = 4'b0100;
        tick();
        chk("s2_req",  32'(cpu_int_req), 32'd1);
        chk("s2_id",   32'(int_id),      32'd2);
        chk("s2_vec",  int_vec,          32'h110);
        chk("s2_busy", 32'(int_busy),    32'd1);
        cpu_int_ack = 1'b1;
        tick();
        cpu_int_ack = 1'b0; int_pend = 4'b0000;
        chk("s2_ack_req", 32'(cpu_int_req), 32'd0);
        chk("s2_ack_clr", 32'(int_clr),     32'b0100);
        tick();
        chk("s2_clr_once", 32'(int_clr), 32'd0);
        chk("s2_serv_busy", 32'(int_busy), 32'd1);
        cpu_eret = 1'b1;
        tick();
        cpu_eret = 1'b0;
        chk("s2_eret_busy", 32'(int_busy), 32'd0);

        // priority under mask
        int_pend = 4'b1010; int_mask = 4'b1000;
        tick();
        chk("pm_id3",  32'(int_id), 32'd3);
        chk("pm_vec3", int_vec,     32'h118);
        cpu_int_ack = 1'b1;
        tick();
        cpu_int_ack = 1'b0; int_pend = 4'b0010; int_mask = 4'b1111;
        chk("pm_clr3", 32'(int_clr), 32'b1000);
        cpu_eret = 1'b1;
        tick();
        cpu_eret = 1'b0;
        chk("pm_idle_req", 32'(cpu_int_req), 32'd0);
        tick();
        chk("pm_req1", 32'(cpu_int_req), 32'd1);
        chk("pm_id1",  32'(int_id),      32'd1);
        chk("pm_vec1", int_vec,          32'h108);

        // request committed: mask/pend changes and eret ignored in REQ
        int_mask = 4'b0000; int_pend = 4'b0001;
        tick();
        chk("req_frozen_req", 32'(cpu_int_req), 32'd1);
        chk("req_frozen_id",  32'(int_id),      32'd1);
        cpu_eret = 1'b1;
        tick();
        cpu_eret = 1'b0;
        chk("eret_in_req_busy", 32'(int_busy),    32'd1);
        chk("eret_in_req_req",  32'(cpu_int_req), 32'd1);
        chk("eret_in_req_clr",  32'(int_clr),     32'd0);
        cpu_int_ack = 1'b1; cpu_eret = 1'b1;
        tick();
        cpu_int_ack = 1'b0; cpu_eret = 1'b0;
        chk("ackeret_req",  32'(cpu_int_req), 32'd0);
        chk("ackeret_clr",  32'(int_clr),     32'b0010);
        chk("ackeret_busy", 32'(int_busy),    32'd1);

        // hold-off in SERV with source 0 now eligible
        int_mask = 4'b1111;
        tick();
        chk("hold_req_a", 32'(cpu_int_req), 32'd0);
        cpu_int_ack = 1'b1;
        tick();
        cpu_int_ack = 1'b0;
        chk("hold_ack_clr", 32'(int_clr),     32'd0);
        chk("hold_req_b",   32'(cpu_int_req), 32'd0);
        cpu_eret = 1'b1;
        tick();
        cpu_eret = 1'b0;
        chk("hold_e1_req",  32'(cpu_int_req), 32'd0);
        chk("hold_e1_busy", 32'(int_busy),    32'd0);
        tick();
        chk("hold_e2_req", 32'(cpu_int_req), 32'd1);
        chk("hold_e2_id",  32'(int_id),      32'd0);
        chk("hold_e2_vec", int_vec,          32'h100);
        cpu_int_ack = 1'b1;
        tick();
        cpu_int_ack = 1'b0; int_pend = 4'b0000;
        chk("s0_clr", 32'(int_clr), 32'b0001);
        cpu_eret = 1'b1;
        tick();
        cpu_eret = 1'b0;

        // spurious ack in IDLE
        cpu_int_ack = 1'b1;
        tick();
        cpu_int_ack = 1'b0;
        chk("idle_ack_clr",  32'(int_clr),  32'd0);
        chk("idle_ack_busy", 32'(int_busy), 32'd0);
        chk("idle_id_held",  32'(int_id),   32'd0);

        // reset in REQ issues no clear, source re-requested afterwards
        int_pend = 4'b1000;
        tick();
        chk("rr_id", 32'(int_id), 32'd3);
        rst_n = 1'b0;
        tick();
        chk("rr_rst_req", 32'(cpu_int_req), 32'd0);
        chk("rr_rst_clr", 32'(int_clr),     32'd0);
        chk("rr_rst_vec", int_vec,          32'd0);
        rst_n = 1'b1;
        tick();
        chk("rr_again_req", 32'(cpu_int_req), 32'd1);
        chk("rr_again_id",  32'(int_id),      32'd3);

`ifdef INT_ACK_TIMEOUT_EN
        // request high for exactly 4 cycles, then drops without a clear
        tick(); tick(); tick();
        chk("to_req_c4", 32'(cpu_int_req), 32'd1);
        chk("to_err_c4", 32'(int_err),     32'd0);
        tick();
        chk("to_req_exp",  32'(cpu_int_req), 32'd0);
        chk("to_err_exp",  32'(int_err),     32'd1);
        chk("to_clr_exp",  32'(int_clr),     32'd0);
        chk("to_busy_exp", 32'(int_busy),    32'd0);
        tick();
        chk("to_rereq", 32'(cpu_int_req), 32'd1);
        chk("to_sticky", 32'(int_err),    32'd1);
        // ack on the expiry cycle wins
        tick(); tick(); tick();
        cpu_int_ack = 1'b1;
        tick();
        cpu_int_ack = 1'b0;
        chk("to_ackwin_clr",  32'(int_clr),  32'b1000);
        chk("to_ackwin_busy", 32'(int_busy), 32'd1);
`else
        for (int i = 0; i < 10; i++) tick();
        chk("nto_req_held", 32'(cpu_int_req), 32'd1);
        chk("nto_err",      32'(int_err),     32'd0);
        cpu_int_ack = 1'b1;
        tick();
        cpu_int_ack = 1'b0;
        chk("nto_ack_clr", 32'(int_clr), 32'b1000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
